// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract unit split into STAGES ripple-carry chunks.
// Each stage adds one CHUNK-wide slice using the carry registered by the
// previous stage; operands and the lower sum slices travel alongside so a
// transaction stays aligned. Valid/ready flow control: the whole pipe
// advances when the output register is empty or being drained.
// WIDTH must be >= 2 and STAGES must divide WIDTH exactly.
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // Ripple-carry adder for one slice; returns {carry_out, slice_sum}.
   function automatic logic [CHUNK:0] ripple_add(
      input logic [CHUNK-1:0] x,
      input logic [CHUNK-1:0] y,
      input logic             c
   );
      logic [CHUNK:0] r;
      logic           cy;
      cy = c;
      for (int i = 0; i < CHUNK; i++) begin
         r[i] = x[i] ^ y[i] ^ cy;
         cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
      end
      r[CHUNK] = cy;
      return r;
   endfunction

   // Replace slice idx of base with chunk.
   function automatic logic [WIDTH-1:0] put_chunk(
      input logic [WIDTH-1:0] base,
      input logic [CHUNK-1:0] chunk,
      input int               idx
   );
      logic [WIDTH-1:0] r;
      r = base;
      r[idx*CHUNK +: CHUNK] = chunk;
      return r;
   endfunction

   // Stage registers: operand A, effective operand B (already inverted for
   // subtract), partially completed sum, slice carry and valid bit.
   logic [WIDTH-1:0] a_r     [STAGES];
   logic [WIDTH-1:0] b_r     [STAGES];
   logic [WIDTH-1:0] sum_r   [STAGES];
   logic             carry_r [STAGES];
   logic             valid_r [STAGES];
   logic             ovf_r;

   // Per-stage inputs (from the ports or the previous stage) and results.
   logic [WIDTH-1:0] src_a_s   [STAGES];
   logic [WIDTH-1:0] src_b_s   [STAGES];
   logic [WIDTH-1:0] src_sum_s [STAGES];
   logic             src_c_s   [STAGES];
   logic             src_v_s   [STAGES];
   logic [CHUNK:0]   add_s     [STAGES];
   logic [WIDTH-1:0] nxt_sum_s [STAGES];

   logic adv_s;
   logic ovf_nxt_s;

   // Whole pipe moves when the output slot is free or being consumed.
   assign adv_s    = !valid_r[LAST] || out_ready;
   assign in_ready = adv_s;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_first
            assign src_a_s[k]   = a;
            assign src_b_s[k]   = b ^ {WIDTH{sub}};
            assign src_sum_s[k] = {WIDTH{1'b0}};
            assign src_c_s[k]   = cin ^ sub;
            assign src_v_s[k]   = in_valid;
         end else begin : g_next
            assign src_a_s[k]   = a_r[k-1];
            assign src_b_s[k]   = b_r[k-1];
            assign src_sum_s[k] = sum_r[k-1];
            assign src_c_s[k]   = carry_r[k-1];
            assign src_v_s[k]   = valid_r[k-1];
         end
         assign add_s[k] = ripple_add(src_a_s[k][k*CHUNK +: CHUNK],
                                      src_b_s[k][k*CHUNK +: CHUNK],
                                      src_c_s[k]);
         assign nxt_sum_s[k] = put_chunk(src_sum_s[k], add_s[k][CHUNK-1:0], k);
      end
   endgenerate

   // Signed overflow is decided when the final slice completes.
   assign ovf_nxt_s = (src_a_s[LAST][WIDTH-1] == src_b_s[LAST][WIDTH-1]) &&
                      (nxt_sum_s[LAST][WIDTH-1] != src_a_s[LAST][WIDTH-1]);

   // Stage registers shift together on advance and hold on stall; reset
   // flushes every in-flight beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            a_r[i]     <= {WIDTH{1'b0}};
            b_r[i]     <= {WIDTH{1'b0}};
            sum_r[i]   <= {WIDTH{1'b0}};
            carry_r[i] <= 1'b0;
            valid_r[i] <= 1'b0;
         end
         ovf_r <= 1'b0;
      end else if (adv_s) begin
         for (int i = 0; i < STAGES; i++) begin
            a_r[i]     <= src_a_s[i];
            b_r[i]     <= src_b_s[i];
            sum_r[i]   <= nxt_sum_s[i];
            carry_r[i] <= add_s[i][CHUNK];
            valid_r[i] <= src_v_s[i];
         end
         ovf_r <= ovf_nxt_s;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            a_r[i]     <= a_r[i];
            b_r[i]     <= b_r[i];
            sum_r[i]   <= sum_r[i];
            carry_r[i] <= carry_r[i];
            valid_r[i] <= valid_r[i];
         end
         ovf_r <= ovf_r;
      end
   end

   assign out_valid = valid_r[LAST];
   assign sum       = sum_r[LAST];
   assign cout      = carry_r[LAST];
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4).
// Inputs are driven and outputs sampled just after the falling edge.
module tb_pipelined_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int total;
   int bad;
   logic [17:0] exp_q [$];

   pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from a full-width addition.
   function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_,
                                         input logic tc, input logic ts);
      logic [15:0] beff;
      logic [16:0] full;
      logic        o;
      beff = tb_ ^ {16{ts}};
      full = {1'b0, ta} + {1'b0, beff} + {16'd0, tc ^ ts};
      o    = (ta[15] == beff[15]) && (full[15] != ta[15]);
      return {o, full};
   endfunction

   // One clock cycle: drive, check ready, score output handshake, log accept.
   task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic ts, input logic tr);
      logic [17:0] e;
      in_valid  = v;
      a         = ta;
      b         = tb_;
      cin       = tc;
      sub       = ts;
      out_ready = tr;
      #1;
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_result", 32'({ovf, cout, sum}), 32'(e));
         end
      end
      if (in_valid && in_ready) exp_q.push_back(model(ta, tb_, tc, ts));
      @(posedge clk);
      @(negedge clk);
   endtask

   // Single beat into an empty pipe: latency and constant result checks.
   task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic ec, input logic eo);
      int n;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      step(1'b1, ta, tb_, tc, ts, 1'b1);
      n = 1;
      while (!out_valid && n < 20) begin
         step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'd4);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
   endtask

   logic [15:0] order_exp [4];

   initial begin
      int idx;
      int cyc;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 16'h1111;
      b         = 16'h2222;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("rst_ignores_in", 32'(out_valid), 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors.
      run_one("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("sub_borrow", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      run_one("cin_add",    16'h00FF, 16'h0100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0);

      // Back-to-back beats with an output stall of three cycles.
      for (int i = 0; i < 4; i++) begin
         order_exp[i] = 16'(2 * (i + 1));
         step(1'b1, 16'(i + 1), 16'(i + 1), 1'b0, 1'b0, 1'b1);
      end
      check("stall_first_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'b1;
         a         = 16'd100;
         b         = 16'd0;
         out_ready = 1'b0;
         #1;
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_sum", 32'(sum), 32'd2);
         check("stall_valid", 32'(out_valid), 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      idx = 0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
         if (out_valid && idx < 4) begin
            check("stall_order", 32'(sum), 32'(order_exp[idx]));
            idx++;
         end
         step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
         cyc++;
      end
      check("stall_count", 32'(idx), 32'd4);
      check("stall_drained", 32'(exp_q.size()), 32'd0);

      // Reset with beats in flight, one result already waiting.
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0010, 16'(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
      check("flush_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_sum", 32'(sum), 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("flush_no_ghost", 32'(out_valid), 32'd0);
      run_one("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Random add/sub traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0));
      end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 50) begin
         step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
         cyc++;
      end
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
